// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the elastic pipeline register
//
// Purpose : state encoding, control-bit indices and the default entry layout
//           used by pipe_stage_reg and pipe_entry_reg.
package pipe_pkg;

  // Occupancy-style state: number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Control-vector bit positions for the EX/MEM instance.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;

  // Entry layout at the default widths (ctrl, destination register, data).
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [4:0]  dst;
    logic [31:0] data;
  } pipe_entry_t;

  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      EMPTY:   occ_of = 2'd0;
      ONE:     occ_of = 2'd1;
      TWO:     occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one valid+payload storage slot with load/clear
//
// Purpose : holds a single pipeline entry. clear drops the valid bit and
//           zeroes the stored control flags; the payload keeps its old value.
// Ports   : clk, rst (async active-low), load, clear, d_ctrl, d_pay,
//           valid, q_ctrl, q_pay
module pipe_entry_reg #(
  parameter int CTRL_W = 4,
  parameter int PAY_W  = 37
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [PAY_W-1:0]  d_pay,
  output logic              valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [PAY_W-1:0]  q_pay
);

  // clear has priority so a flush always beats a same-edge load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
      q_pay  <= '0;
    end else if (clear) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      q_ctrl <= d_ctrl;
      q_pay  <= d_pay;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic inter-stage pipeline register with optional skid slot
//
// Purpose : carries {data, dst reg, ctrl} between two pipeline stages with a
//           valid/ready handshake, flush with bubble insertion, and (SKID=1)
//           a second slot so in_ready comes straight from a flop.
// Ports   : clk, rst (async active-low)
//           in_valid/in_ready/in_data/in_reg/in_ctrl  upstream side
//           flush                                     synchronous kill
//           out_valid/out_ready/out_data/out_reg/out_ctrl downstream side
//           occupancy                                 held entries (0..2)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]  in_reg,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_W-1:0]  out_reg,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int PAY_W = DATA_W + REG_W;

  state_t state, next_state;
  logic   in_ready_q;
  logic   accept, pop;
  logic   main_valid, skid_valid;
  logic   main_load, main_from_skid, main_clear, skid_load, skid_clear;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [PAY_W-1:0]  main_pay, skid_pay, main_d_pay, in_pay;

  assign in_pay    = {in_reg, in_data};
  assign out_valid = main_valid;
  assign pop       = main_valid & out_ready;
  assign in_ready  = (SKID != 0) ? in_ready_q : (~main_valid | out_ready);
  assign accept    = in_valid & in_ready;

  always_comb begin
    next_state     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state = ONE;
          main_load  = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept && (SKID != 0)) begin
          next_state = TWO;
          skid_load  = 1'b1;
        end else if (accept) begin
          main_load = 1'b1;
        end else if (pop) begin
          next_state = EMPTY;
          main_clear = 1'b1;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can move the state.
        if (pop && skid_valid) begin
          next_state     = ONE;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
    if (flush) begin
      next_state     = EMPTY;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      main_clear     = 1'b1;
      skid_clear     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != TWO);
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_pay  = main_from_skid ? skid_pay  : in_pay;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load | main_from_skid),
    .clear  (main_clear),
    .d_ctrl (main_d_ctrl),
    .d_pay  (main_d_pay),
    .valid  (main_valid),
    .q_ctrl (main_ctrl),
    .q_pay  (main_pay)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry_reg #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_ctrl (in_ctrl),
      .d_pay  (in_pay),
      .valid  (skid_valid),
      .q_ctrl (skid_ctrl),
      .q_pay  (skid_pay)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_pay   = '0;
  end

  // Bubbles must never carry RegWrite/MemWrite downstream.
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data  = main_pay[DATA_W-1:0];
  assign out_reg   = main_pay[PAY_W-1:DATA_W];
  assign occupancy = occ_of(state);

endmodule
